// File: rtl/divider_if.sv
// rtl/divider_if.sv - start/done handshake bundle for the sequential divider
// Purpose: groups the request (start, dividend, divisor) and the result
//          (quotient, remainder, done, busy, div_zero) signals.
// Ports (via modports):
//   master - drives start/dividend/divisor, observes results
//   slave  - the divider: consumes the request, drives results
interface divider_if #(
  parameter int width = 16
);
  logic                 start;
  logic [2*width-1:0]   dividend;
  logic [width-1:0]     divisor;
  logic [2*width-1:0]   quotient;
  logic [width-1:0]     remainder;
  logic                 done;
  logic                 busy;
  logic                 div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_zero
  );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring shift-subtract divider, one quotient bit per clock
// Purpose: unsigned 2W/W division; 2W-bit quotient and W-bit remainder with a
//          one-cycle done pulse, 2W cycles after the accepted start.
// Ports:
//   clk     - clock, posedge
//   reset_n - asynchronous active-low reset
//   bus     - divider_if.slave: start/dividend/divisor in;
//             quotient/remainder/done/busy/div_zero out
// Option: DIVIDER_DIVZERO_EN - zero divisor finishes early and raises div_zero.
module divider #(
  parameter int width = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  divider_if.slave  bus
);
  localparam int DW = 2 * width;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after 2W steps this register holds the quotient.
  logic [DW-1:0]   dvd_q, dvd_d;
  // The partial remainder is always < divisor between steps, so W bits hold
  // it; only the freshly shifted value needs the extra bit.
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] dsr_q, dsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [width-1:0] rmd_q, rmd_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [width:0]   r_shift;
  logic [width-1:0] r_sub;
  logic             q_bit;

`ifdef DIVIDER_DIVZERO_EN
  logic dz_q, dz_d;
  // Set on accepting a zero divisor; the results are published one cycle later.
  logic dz_pend_q, dz_pend_d;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef DIVIDER_DIVZERO_EN
    dz_d      = dz_q;
    dz_pend_d = dz_pend_q;
`endif

    r_shift = {rem_q, dvd_q[DW-1]};
    q_bit   = (r_shift >= {1'b0, dsr_q});
    // True difference is below 2^W whenever q_bit is set, so low bits suffice.
    r_sub   = r_shift[width-1:0] - dsr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIVIDER_DIVZERO_EN
          dz_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d   = DONE;
            dz_pend_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = RUN;
          busy_d  = 1'b1;
`endif
        end
      end

      RUN: begin
        rem_d = q_bit ? r_sub : r_shift[width-1:0];
        dvd_d = {dvd_q[DW-2:0], q_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = {dvd_q[DW-2:0], q_bit};
          rmd_d   = q_bit ? r_sub : r_shift[width-1:0];
        end
      end

      DONE: begin
`ifdef DIVIDER_DIVZERO_EN
        if (dz_pend_q) begin
          dz_pend_d = 1'b0;
          done_d    = 1'b1;
          dz_d      = 1'b1;
          quo_d     = '1;
          rmd_d     = dvd_q[width-1:0];
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DIVIDER_DIVZERO_EN
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef DIVIDER_DIVZERO_EN
      dz_q      <= dz_d;
      dz_pend_q <= dz_pend_d;
`endif
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
`ifdef DIVIDER_DIVZERO_EN
  assign bus.div_zero  = dz_q;
`else
  assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
module tb_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  divider_if #(.width(W)) bus();
  divider #(.width(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Issues one request and watches it; sample j=0 is the negedge after the
  // accepting edge, so a done seen at sample j means done rose at edge j.
  task automatic do_div(input logic [31:0] a, input logic [15:0] b,
                        output int lat, output int bcnt,
                        output logic [31:0] q, output logic [15:0] r,
                        output logic dz, output logic done_next);
    lat = -1; bcnt = 0; q = '0; r = '0; dz = 1'b0; done_next = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = 16'(($urandom % 16'hFFFF) + 1);
    for (int j = 0; j < 100; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = j; q = bus.quotient; r = bus.remainder; dz = bus.div_zero;
        break;
      end
    end
    @(negedge clk);
    done_next = bus.done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.quotient !== 32'd0 || bus.remainder !== 16'd0 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b dz=%b required all zero",
               bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_zero);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [31:0] q; logic [15:0] r; logic dz, dn;
    do_div(32'd1000, 16'd7, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (lat !== 32) begin n_fail++; $display("FAIL basic_latency: got %0d required 32", lat); end
    n_tests++;
    if (q !== 32'd142 || r !== 16'd6) begin
      n_fail++; $display("FAIL basic_result: got q=%0d r=%0d required q=142 r=6", q, r);
    end
    n_tests++;
    if (bcnt !== 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required 32", bcnt); end
    n_tests++;
    if (dn !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got done=%b after pulse required 0", dn); end
    n_tests++;
    if (bus.quotient !== 32'd142 || bus.remainder !== 16'd6) begin
      n_fail++; $display("FAIL basic_hold: got q=%0d r=%0d required q=142 r=6", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt, exp_lat, exp_b; logic [31:0] q; logic [15:0] r; logic dz, dn, exp_dz;
`ifdef DIVIDER_DIVZERO_EN
    exp_lat = 1;  exp_dz = 1'b1; exp_b = 0;
`else
    exp_lat = 32; exp_dz = 1'b0; exp_b = 32;
`endif
    do_div(32'h12345678, 16'd0, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (q !== 32'hFFFFFFFF || r !== 16'h5678) begin
      n_fail++; $display("FAIL divzero_result: got q=%h r=%h required q=ffffffff r=5678", q, r);
    end
    n_tests++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL divzero_latency: got %0d required %0d", lat, exp_lat); end
    n_tests++;
    if (dz !== exp_dz) begin n_fail++; $display("FAIL divzero_flag: got %b required %b", dz, exp_dz); end
    n_tests++;
    if (bcnt !== exp_b) begin n_fail++; $display("FAIL divzero_busy: got %0d required %0d", bcnt, exp_b); end
    n_tests++;
    if (bus.div_zero !== exp_dz || dn !== 1'b0) begin
      n_fail++; $display("FAIL divzero_sticky: got dz=%b done=%b required dz=%b done=0", bus.div_zero, dn, exp_dz);
    end
  endtask

  task automatic test_extremes();
    int lat, bcnt; logic [31:0] q; logic [15:0] r; logic dz, dn;
    do_div(32'hFFFFFFFF, 16'hFFFF, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (q !== 32'h00010001 || r !== 16'h0000 || lat !== 32) begin
      n_fail++; $display("FAIL extremes_max: got q=%h r=%h lat=%0d required q=00010001 r=0000 lat=32", q, r, lat);
    end
    n_tests++;
    if (dz !== 1'b0) begin n_fail++; $display("FAIL extremes_dz_cleared: got %b required 0", dz); end
    do_div(32'd5, 16'd9, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (q !== 32'd0 || r !== 16'd5) begin
      n_fail++; $display("FAIL extremes_small: got q=%0d r=%0d required q=0 r=5", q, r);
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first; logic [31:0] q; logic [15:0] r;
    ndone = 0; first = -1; q = '0; r = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd3;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      bus.start = (j == 10);
      if (j == 10) begin bus.dividend = 32'd50; bus.divisor = 16'd5; end
      if (bus.done) begin
        ndone++;
        if (first < 0) begin first = j; q = bus.quotient; r = bus.remainder; end
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (ndone !== 1 || first !== 32) begin
      n_fail++; $display("FAIL busy_start_done: got %0d dones first at %0d required 1 at 32", ndone, first);
    end
    n_tests++;
    if (q !== 32'd33 || r !== 16'd1) begin
      n_fail++; $display("FAIL busy_start_result: got q=%0d r=%0d required q=33 r=1", q, r);
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bcnt; logic [31:0] q; logic [15:0] r; logic dz, dn;
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 1; j < 15; j++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.quotient !== 32'd0 || bus.remainder !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_clear: got q=%0d r=%0d busy=%b done=%b required zeros",
                         bus.quotient, bus.remainder, bus.busy, bus.done);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d dones required 0", ndone); end
    do_div(32'd77, 16'd7, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (q !== 32'd11 || r !== 16'd0 || lat !== 32) begin
      n_fail++; $display("FAIL reset_mid_restart: got q=%0d r=%0d lat=%0d required q=11 r=0 lat=32", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 60 && !seen; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL b2b_first_done: got no done within bound required one"); end
    // Request during the DONE cycle must be dropped.
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 16'd5) begin
      n_fail++; $display("FAIL b2b_done_start_ignored: got busy=%b done=%b q=%0d r=%0d required 0 0 0 5",
                         bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    begin
      int bcnt; logic [31:0] q; logic [15:0] r; logic dz, dn;
      do_div(32'd1000, 16'd7, lat, bcnt, q, r, dz, dn);
      n_tests++;
      if (q !== 32'd142 || r !== 16'd6 || lat !== 32) begin
        n_fail++; $display("FAIL b2b_next: got q=%0d r=%0d lat=%0d required q=142 r=6 lat=32", q, r, lat);
      end
    end
  endtask

  task automatic test_roundtrip();
    int lat, bcnt, nbad; logic [31:0] q, a, prod; logic [15:0] r, b; logic dz, dn;
    logic [63:0] recon;
    prod = 32'hBEEF * 32'h1234;
    do_div(prod, 16'h1234, lat, bcnt, q, r, dz, dn);
    n_tests++;
    if (q !== 32'h0000BEEF || r !== 16'd0) begin
      n_fail++; $display("FAIL roundtrip_beef: got q=%h r=%h required q=0000beef r=0000", q, r);
    end
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      do_div(a, b, lat, bcnt, q, r, dz, dn);
      recon = 64'(q) * 64'(b) + 64'(r);
      n_tests++;
      if (recon !== 64'(a) || r >= b || q !== a / 32'(b) || lat !== 32) begin
        n_fail++; nbad++;
        if (nbad <= 5)
          $display("FAIL roundtrip_random: a=%h b=%h got q=%h r=%h lat=%0d required q=%h r=%h lat=32",
                   a, b, q, r, lat, a / 32'(b), 16'(a % 32'(b)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_extremes();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
